// File: rtl/fpu_cpu_port.sv
// Byte-wide CPU register port that loads FPU operands, launches one operation and latches its result.
// Latency: CMD write in cycle N gives fpu_start in N+1; result is latched the cycle after fpu_end is seen; reads return data one cycle later.
// Backpressure: bus writes to operands/CMD are dropped while busy; a CMD is deferred while a stale fpu_end is drained.
module fpu_cpu_port #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        irq,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [3:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_end,
    input  logic [31:0] fpu_result,
    output logic        fpu_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_ACK
    } state_t;

    // The wait counter starts at 0 in the first WAIT cycle and expires when its
    // increment would reach TIMEOUT_CYC-1, so START plus WAIT spans TIMEOUT_CYC cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     result;
    logic            busy;
    logic            done;
    logic            bad_op;
    logic            timeout;
    logic            irq_en;
    logic            pend;
    logic            wr_acc;
    logic            rd_acc;
    logic            cmd_wr;
    logic [7:0]      rd_mux;
    logic [7:0]      status;

    // A write in the same cycle as a read takes priority; the read is ignored.
    assign wr_acc = cs & wr;
    assign rd_acc = cs & rd & ~wr;
    assign cmd_wr = wr_acc && (addr == 4'h8);
    assign status = {4'b0000, timeout, bad_op, done, busy};
    assign irq    = done & irq_en;

    // Read data selection by register address; write-only and unmapped slots return zero.
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            4'h0: rd_mux = fpu_a[7:0];
            4'h1: rd_mux = fpu_a[15:8];
            4'h2: rd_mux = fpu_a[23:16];
            4'h3: rd_mux = fpu_a[31:24];
            4'h4: rd_mux = fpu_b[7:0];
            4'h5: rd_mux = fpu_b[15:8];
            4'h6: rd_mux = fpu_b[23:16];
            4'h7: rd_mux = fpu_b[31:24];
            4'h9: rd_mux = status;
            4'hC: rd_mux = result[7:0];
            4'hD: rd_mux = result[15:8];
            4'hE: rd_mux = result[23:16];
            4'hF: rd_mux = result[31:24];
            default: rd_mux = 8'h00;
        endcase
    end

    // Registered read data, updated only by an accepted read.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            data_out <= 8'h00;
        end else if (rd_acc) begin
            data_out <= rd_mux;
        end
    end

    // Operand byte writes; blocked while busy so the FPU sees stable operands.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            fpu_a <= 32'h0;
            fpu_b <= 32'h0;
        end else if (wr_acc && !busy) begin
            case (addr)
                4'h0: fpu_a[7:0]   <= data_in;
                4'h1: fpu_a[15:8]  <= data_in;
                4'h2: fpu_a[23:16] <= data_in;
                4'h3: fpu_a[31:24] <= data_in;
                4'h4: fpu_b[7:0]   <= data_in;
                4'h5: fpu_b[15:8]  <= data_in;
                4'h6: fpu_b[23:16] <= data_in;
                4'h7: fpu_b[31:24] <= data_in;
                default: ;
            endcase
        end
    end

    // Command sequencer: launch, wait with timeout, capture, ack handshake, status bits.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            result    <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad_op    <= 1'b0;
            timeout   <= 1'b0;
            irq_en    <= 1'b0;
            pend      <= 1'b0;
            fpu_op    <= 4'h0;
            fpu_start <= 1'b0;
            fpu_ack   <= 1'b0;
        end else begin
            fpu_start <= 1'b0;
            if (rd_acc && (addr == 4'hF)) begin
                done <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    // A leftover fpu_end (late result or pre-reset op) is acked and discarded.
                    fpu_ack <= fpu_end;
                    if (pend) begin
                        if (!fpu_end) begin
                            pend      <= 1'b0;
                            fpu_start <= 1'b1;
                            state     <= S_START;
                        end
                    end else if (cmd_wr && !busy) begin
                        if (data_in[3:0] > 4'hC) begin
                            bad_op <= 1'b1;
                            done   <= 1'b0;
                        end else begin
                            fpu_op  <= data_in[3:0];
                            irq_en  <= data_in[7];
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            timeout <= 1'b0;
                            bad_op  <= 1'b0;
                            if (fpu_end) begin
                                pend <= 1'b1;
                            end else begin
                                fpu_start <= 1'b1;
                                state     <= S_START;
                            end
                        end
                    end
                end
                S_START: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_end) begin
                        state <= S_CAPTURE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result  <= fpu_result;
                    fpu_ack <= 1'b1;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    if (!fpu_end) begin
                        fpu_ack <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cpu_port.sv
`timescale 1ns/1ps
module tb_fpu_cpu_port;

    logic        clk = 1'b0;
    logic        arst;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        irq;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [3:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_end;
    logic [31:0] fpu_result;
    logic        fpu_ack;

    fpu_cpu_port #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk        (clk),
        .arst       (arst),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .irq        (irq),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_start  (fpu_start),
        .fpu_end    (fpu_end),
        .fpu_result (fpu_result),
        .fpu_ack    (fpu_ack)
    );

    always #5 clk = ~clk;

    // FPU model controls; latency is kept below the 16-cycle timeout for normal ops
    int          model_lat  = 10;
    bit          model_hang = 1'b0;
    int          ack_hold   = 0;
    bit          saw_ack    = 1'b0;
    logic [31:0] next_res   = 32'h0;
    int          start_cnt  = 0;
    logic [31:0] cap_a, cap_b;
    logic [3:0]  cap_op;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] res_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  cmd;
        logic [31:0] res;
        bit          bad;
    } vec_t;

    vec_t        vecs[7];
    vec_t        v;
    int          sc;
    int          n;
    logic        e1, e2;
    logic [7:0]  d;

    // Count every start pulse independently of the model sequence
    initial forever begin
        @(posedge clk); #1;
        if (fpu_start) start_cnt++;
    end

    // FPU model: after start, wait model_lat cycles, raise fpu_end, drop it after ack_hold+1 ack cycles
    initial begin : fpu_model
        fpu_end    = 1'b0;
        fpu_result = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (fpu_start) begin
                cap_a  = fpu_a;
                cap_b  = fpu_b;
                cap_op = fpu_op;
                if (!model_hang) begin
                    int acks;
                    int guard;
                    repeat (model_lat - 1) begin @(posedge clk); #1; end
                    fpu_end    = 1'b1;
                    fpu_result = next_res;
                    acks  = 0;
                    guard = 0;
                    while (acks <= ack_hold && guard < 200) begin
                        @(posedge clk); #1;
                        guard++;
                        if (fpu_ack) begin
                            acks++;
                            saw_ack = 1'b1;
                        end
                    end
                    fpu_end  = 1'b0;
                    ack_hold = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] dat);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; data_in = dat;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] dat);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        dat = data_out;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] e);
        logic [7:0] got;
        exp_q.push_back(e);
        bus_rd(a, got);
        chk(name, {24'h0, got}, {24'h0, exp_q.pop_front()});
    endtask

    task automatic wr_ops(input logic [31:0] a, input logic [31:0] b);
        for (int j = 0; j < 4; j++) begin
            bus_wr(4'(j), a[8*j +: 8]);
            bus_wr(4'(4 + j), b[8*j +: 8]);
        end
    endtask

    // Poll STATUS until the masked value matches, bounded by 100 reads
    task automatic wait_status(input string name, input logic [7:0] mask, input logic [7:0] val);
        logic [7:0] got;
        int cnt;
        cnt = 0;
        do begin
            bus_rd(4'h9, got);
            cnt++;
        end while (((got & mask) != val) && cnt < 100);
        chk(name, {24'h0, got & mask}, {24'h0, val});
    endtask

    task automatic chk_result(input string name);
        logic [31:0] r;
        logic [7:0]  got;
        for (int j = 0; j < 4; j++) begin
            bus_rd(4'(12 + j), got);
            r[8*j +: 8] = got;
        end
        chk(name, r, res_q.pop_front());
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        arst = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_data_out", {24'h0, data_out}, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_fpu_op", {28'h0, fpu_op}, 0);
        chk("rst_ctrl", {29'h0, fpu_start, fpu_ack, irq}, 0);
        arst = 1'b1;
        rd_chk("rst_status", 4'h9, 8'h00);
        rd_chk("unmapped_A", 4'hA, 8'h00);
        rd_chk("cmd_reads_zero", 4'h8, 8'h00);

        vecs[0] = '{32'h3F800000, 32'h40000000, 8'h00, 32'h40400000, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h40000000, 8'h8D, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 8'h03, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{32'hC0A00000, 32'h3F000000, 8'h0C, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{32'h00000001, 32'hFFFFFFFF, 8'h0D, 32'h00000000, 1'b1};
        vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 8'h0F, 32'h00000000, 1'b1};
        vecs[6] = '{32'h40400000, 32'h3F800000, 8'h82, 32'h40800000, 1'b0};

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            wr_ops(v.a, v.b);
            next_res = v.res;
            sc = start_cnt;
            if (!v.bad) res_q.push_back(v.res);
            bus_wr(4'h8, v.cmd);
            chk("start_at_n1", {31'h0, fpu_start}, {31'h0, !v.bad});
            if (v.bad) begin
                repeat (3) @(negedge clk);
                chk("bad_no_start", 32'(start_cnt - sc), 0);
                rd_chk("bad_status", 4'h9, 8'h04);
                chk("bad_irq", {31'h0, irq}, 0);
            end else begin
                chk("start_a", cap_a, v.a);
                chk("start_b", cap_b, v.b);
                chk("start_op", {28'h0, cap_op}, {28'h0, v.cmd[3:0]});
                wait_status("done", 8'h0F, 8'h02);
                chk("irq_done", {31'h0, irq}, {31'h0, v.cmd[7]});
                chk_result("result");
                chk("irq_after_F", {31'h0, irq}, 0);
                rd_chk("status_after_F", 4'h9, 8'h00);
            end
        end

        // Operand and CMD writes while busy are dropped
        wr_ops(32'h3F800000, 32'h40000000);
        next_res = 32'h40400000;
        res_q.push_back(32'h40400000);
        sc = start_cnt;
        bus_wr(4'h8, 8'h00);
        bus_wr(4'h0, 8'hFF);
        bus_wr(4'h8, 8'h05);
        chk("busy_a_frozen", fpu_a, 32'h3F800000);
        chk("busy_op_frozen", {28'h0, fpu_op}, 0);
        wait_status("busy_done", 8'h0F, 8'h02);
        chk("busy_one_start", 32'(start_cnt - sc), 1);
        chk_result("busy_result");
        rd_chk("busy_a0", 4'h0, 8'h00);

        // Simultaneous read and write: write wins, data_out holds
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h0; data_in = 8'h5A;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        chk("rdwr_hold", {24'h0, data_out}, 32'h00);
        rd_chk("rdwr_written", 4'h0, 8'h5A);

        // Timeout: model never ends; status flips exactly 16 cycles after start
        model_hang = 1'b1;
        bus_wr(4'h8, 8'h01);
        chk("to_start", {31'h0, fpu_start}, 1);
        repeat (15) @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 4'h9;
        @(negedge clk);
        chk("to_before_16", {24'h0, data_out}, 32'h01);
        @(negedge clk);
        chk("to_at_16", {24'h0, data_out}, 32'h08);
        cs = 1'b0; rd = 1'b0;
        model_hang = 1'b0;

        // Late end after timeout: drained in IDLE, done stays 0
        model_lat = 20;
        saw_ack   = 1'b0;
        bus_wr(4'h8, 8'h01);
        wait_status("late_timeout", 8'h0F, 8'h08);
        n = 0;
        while (!(saw_ack && !fpu_end) && n < 100) begin @(negedge clk); n++; end
        chk("late_ack_seen", {31'h0, saw_ack}, 1);
        @(negedge clk);
        chk("late_ack_low", {31'h0, fpu_ack}, 0);
        rd_chk("late_status", 4'h9, 8'h08);
        model_lat = 10;

        // Reset while in ACK with fpu_end high, then stale drain and deferred CMD
        ack_hold = 8;
        bus_wr(4'h8, 8'h80);
        n = 0;
        while (!(fpu_ack && fpu_end) && n < 60) begin @(negedge clk); n++; end
        chk("rst_in_ack", {31'h0, fpu_ack & fpu_end}, 1);
        arst = 1'b0;
        #1;
        chk("arst_ack", {31'h0, fpu_ack}, 0);
        chk("arst_start_irq", {30'h0, fpu_start, irq}, 0);
        chk("arst_a", fpu_a, 0);
        chk("arst_b", fpu_b, 0);
        chk("arst_op_dout", {20'h0, fpu_op, data_out}, 0);
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        chk("stale_ack_high", {30'h0, fpu_ack, fpu_end}, 32'h3);
        next_res = 32'h55667788;
        res_q.push_back(32'h55667788);
        bus_wr(4'h8, 8'h03);
        chk("defer_no_start", {30'h0, fpu_start, fpu_end}, 32'h1);
        e1 = 1'b1; e2 = 1'b1; n = 0;
        while (!fpu_start && n < 60) begin e2 = e1; e1 = fpu_end; @(negedge clk); n++; end
        chk("defer_started", {31'h0, fpu_start}, 1);
        chk("defer_end_low_before", {31'h0, e1}, 0);
        chk("defer_end_high_2before", {31'h0, e2}, 1);
        chk("defer_op", {28'h0, cap_op}, 32'h3);
        wait_status("defer_done", 8'h0F, 8'h02);
        chk("defer_irq_off", {31'h0, irq}, 0);
        chk_result("defer_result");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
